// File: rtl/popcount_pkg.sv
// Shared constants and width helpers for the popcount accumulator.
package popcount_pkg;

  localparam logic MODE_COUNT = 1'b0;
  localparam logic MODE_ACCUM = 1'b1;

  function automatic int cnt_w(input int n_in);
    return $clog2(n_in + 1);
  endfunction

  function automatic int acc_w(input int n_in, input int max_beats);
    return $clog2(n_in * max_beats + 1);
  endfunction

  function automatic int beat_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational ones-counter: N_IN input bits reduced to a CNT_W-bit count.
module popcount_tree #(
  parameter int N_IN  = 9,
  parameter int CNT_W = 4
) (
  input  logic [N_IN-1:0]  bits,
  output logic [CNT_W-1:0] cnt
);

  // Written as a flat sum; synthesis rebalances it into an adder tree.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt = cnt + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/popcount_accum.sv
// Pipelined popcount with optional per-group accumulation closed by in_last or MAX_BEATS.
module popcount_accum
  import popcount_pkg::*;
#(
  parameter  int N_IN      = 9,
  parameter  int MAX_BEATS = 16,
  parameter  int PIPE      = 1,
  localparam int CNT_W     = cnt_w(N_IN),
  localparam int ACC_W     = acc_w(N_IN, MAX_BEATS),
  localparam int BEAT_W    = beat_w(MAX_BEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_bits,
  input  logic              in_last,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_overflow
);

  // Handshake: a beat transfers on a rising edge where in_valid & in_ready; a result
  // transfers where out_valid & out_ready. Valid is never withdrawn before transfer.
  logic             stall;
  logic             fire;
  logic [CNT_W-1:0] tree_cnt;
  logic             s1_valid;
  logic             s1_last;
  logic             s1_mode;
  logic [CNT_W-1:0] s1_cnt;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & ~reset;
  assign fire     = in_valid & in_ready;

  popcount_tree #(.N_IN(N_IN), .CNT_W(CNT_W)) u_tree (
    .bits (in_bits),
    .cnt  (tree_cnt)
  );

  generate
    if (PIPE != 0) begin : g_pipe
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_valid <= 1'b0;
          s1_cnt   <= '0;
          s1_last  <= 1'b0;
          s1_mode  <= MODE_COUNT;
        end else if (!stall) begin
          s1_valid <= fire;
          if (fire) begin
            s1_cnt  <= tree_cnt;
            s1_last <= in_last;
            s1_mode <= mode;
          end
        end
      end
    end else begin : g_comb
      always_comb begin
        s1_valid = fire;
        s1_cnt   = tree_cnt;
        s1_last  = in_last;
        s1_mode  = mode;
      end
    end
  endgenerate

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beats_next;
  logic              grp_mode;
  logic              g_mode;
  logic              first;
  logic              advance;
  logic              close;
  logic              ovf;

  // The group's mode is taken from its first beat; later beats' mode is ignored.
  always_comb begin
    advance    = s1_valid & ~stall;
    first      = (beat_cnt == '0);
    g_mode     = first ? s1_mode : grp_mode;
    acc_next   = (first ? '0 : acc) + ACC_W'(s1_cnt);
    beats_next = (first ? '0 : beat_cnt) + BEAT_W'(1);
    close      = (g_mode == MODE_COUNT) | s1_last | (beats_next == BEAT_W'(MAX_BEATS));
    ovf        = (g_mode == MODE_ACCUM) & ~s1_last & (beats_next == BEAT_W'(MAX_BEATS));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      beat_cnt     <= '0;
      grp_mode     <= MODE_COUNT;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_beats    <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (advance) begin
        if (first) grp_mode <= s1_mode;
        if (close) begin
          acc          <= '0;
          beat_cnt     <= '0;
          out_sum      <= acc_next;
          out_beats    <= beats_next;
          out_overflow <= ovf;
        end else begin
          acc      <= acc_next;
          beat_cnt <= beats_next;
        end
      end
      // A new close while the old result is taken keeps out_valid high back-to-back.
      if (advance && close) out_valid <= 1'b1;
      else if (out_ready)   out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// Bench for popcount_accum: directed and random beats against a group-level reference model.
module tb_popcount_accum;

  localparam int N_IN      = 9;
  localparam int MAX_BEATS = 4;
  localparam int ACC_W     = $clog2(N_IN * MAX_BEATS + 1);
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam int W         = 1 + BEAT_W + ACC_W;
  localparam int ACC_W_B   = $clog2(1 * 16 + 1);
  localparam int BEAT_W_B  = $clog2(16 + 1);

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_bits;
  logic              in_last;
  logic              mode;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_sum;
  logic [BEAT_W-1:0] out_beats;
  logic              out_overflow;

  logic                in_valid_b;
  logic                in_ready_b;
  logic [0:0]          in_bits_b;
  logic                in_last_b;
  logic                mode_b;
  logic                out_valid_b;
  logic                out_ready_b;
  logic [ACC_W_B-1:0]  out_sum_b;
  logic [BEAT_W_B-1:0] out_beats_b;
  logic                out_overflow_b;

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  logic [W-1:0] exp_q[$];
  int   m_n;
  int   m_sum;
  logic m_mode;

  popcount_accum #(.N_IN(N_IN), .MAX_BEATS(MAX_BEATS), .PIPE(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bits      (in_bits),
    .in_last      (in_last),
    .mode         (mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_beats    (out_beats),
    .out_overflow (out_overflow)
  );

  popcount_accum #(.N_IN(1), .MAX_BEATS(16), .PIPE(0)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid_b),
    .in_ready     (in_ready_b),
    .in_bits      (in_bits_b),
    .in_last      (in_last_b),
    .mode         (mode_b),
    .out_valid    (out_valid_b),
    .out_ready    (out_ready_b),
    .out_sum      (out_sum_b),
    .out_beats    (out_beats_b),
    .out_overflow (out_overflow_b)
  );

  // Clock and consumer-ready generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: groups of accepted beats, totals from $countones.
  task automatic model_beat(input logic [N_IN-1:0] bits, input logic last, input logic md);
    logic ovf;
    if (m_n == 0) m_mode = md;
    m_sum += $countones(bits);
    m_n++;
    if (m_mode == 1'b0 || last || m_n == MAX_BEATS) begin
      ovf = m_mode && !last && (m_n == MAX_BEATS);
      exp_q.push_back({ovf, BEAT_W'(m_n), ACC_W'(m_sum)});
      m_n   = 0;
      m_sum = 0;
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    m_n   = 0;
    m_sum = 0;
  endtask

  // Driver: present a beat until it is accepted; returns 1 ns after the accepting edge.
  task automatic send_beat(input logic [N_IN-1:0] bits, input logic last, input logic md);
    bit got = 0;
    int n = 0;
    in_valid = 1'b1;
    in_bits  = bits;
    in_last  = last;
    mode     = md;
    while (!got && n < 100) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("send_accepted", 32'(got), 32'd1);
    if (got) model_beat(bits, last, md);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    idle(2);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every completed output handshake consumes one expected result.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'({out_overflow, out_beats, out_sum}), 32'hFFFF);
      end else begin
        check("result", 32'({out_overflow, out_beats, out_sum}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [N_IN-1:0] a_bits;
    int len;
    logic md;
    logic grp_md;

    reset       = 1'b1;
    in_valid    = 1'b0;
    in_bits     = '0;
    in_last     = 1'b0;
    mode        = 1'b0;
    in_valid_b  = 1'b0;
    in_bits_b   = '0;
    in_last_b   = 1'b0;
    mode_b      = 1'b0;
    out_ready_b = 1'b1;
    model_flush();

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_beats", 32'(out_beats), 32'd0);
    check("rst_out_overflow", 32'(out_overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Count mode with two-stage latency
    send_beat(9'h1FF, 1'b0, 1'b0);
    @(negedge clk);
    check("cnt_lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("cnt_lat_valid", 32'(out_valid), 32'd1);
    check("cnt_sum_9", 32'(out_sum), 32'd9);
    idle(2);
    send_beat(9'h000, 1'b1, 1'b0);
    @(negedge clk);
    check("cnt_lat_early0", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("cnt_lat_valid0", 32'(out_valid), 32'd1);
    check("cnt_sum_0", 32'(out_sum), 32'd0);
    drain("drain_count");

    // Accumulate: 3-beat group, 6 beats forced over MAX_BEATS, last exactly at MAX_BEATS
    send_beat(9'h0FF, 1'b0, 1'b1);
    send_beat(9'h001, 1'b0, 1'b0);
    send_beat(9'h100, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) send_beat(9'h1FF, (i == 5), 1'b1);
    for (int i = 0; i < 4; i++) send_beat(9'h003, (i == 3), 1'b1);
    drain("drain_accum");

    // Back-pressure: consumer stalls while beats keep arriving
    ready_mode = 0;
    a_bits = N_IN'($urandom);
    send_beat(a_bits, 1'b0, 1'b0);
    send_beat(N_IN'($urandom), 1'b0, 1'b0);
    in_valid = 1'b1;
    in_bits  = N_IN'($urandom);
    in_last  = 1'b0;
    mode     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_sum_hold", 32'(out_sum), 32'($countones(a_bits)));
      @(posedge clk);
      #1;
    end
    ready_mode = 1;
    send_beat(in_bits, 1'b0, 1'b0);
    drain("drain_backpressure");

    // Random groups with random consumer readiness and mid-group mode flips
    ready_mode = 2;
    for (int g = 0; g < 40; g++) begin
      grp_md = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        md = (b == 0) ? grp_md : 1'($urandom_range(0, 1));
        send_beat(N_IN'($urandom), grp_md ? (b == len - 1) : 1'($urandom_range(0, 1)), md);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    ready_mode = 1;
    drain("drain_random");

    // Reset in the middle of an accumulate group
    send_beat(9'h1FF, 1'b0, 1'b1);
    send_beat(9'h0F0, 1'b0, 1'b1);
    idle(2);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_sum", 32'(out_sum), 32'd0);
    check("mid_rst_out_beats", 32'(out_beats), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    model_flush();
    idle(2);
    reset = 1'b0;
    idle(1);
    send_beat(9'h003, 1'b0, 1'b1);
    send_beat(9'h001, 1'b1, 1'b1);
    drain("drain_after_reset");

    // Single-bit, unpipelined instance: alternating beats in count mode
    @(negedge clk);
    check("b_idle_valid", 32'(out_valid_b), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      in_valid_b = 1'b1;
      in_bits_b  = 1'((i + 1) % 2);
      @(negedge clk);
      check("b_in_ready", 32'(in_ready_b), 32'd1);
      if (i > 0) begin
        check("b_valid", 32'(out_valid_b), 32'd1);
        check("b_sum", 32'(out_sum_b), 32'(i % 2));
        check("b_beats", 32'(out_beats_b), 32'd1);
      end
      @(posedge clk);
      #1;
    end
    in_valid_b = 1'b0;
    @(negedge clk);
    check("b_valid_last", 32'(out_valid_b), 32'd1);
    check("b_sum_last", 32'(out_sum_b), 32'd0);
    @(negedge clk);
    check("b_valid_clear", 32'(out_valid_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
